// File: rtl/lsu.sv
// Load/store unit: one memory transaction per load/store, byte-lane steering and load extension.
// Optional misaligned-access trap compiled in with `LSU_MISALIGN_CHECK_EN.
module lsu (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_misalign_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [DW-1:0]  rd_q, rd_d;
    logic [DW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  wd_q, wd_d;
    logic [BW-1:0]  be_q, be_d;
    logic [2:0]     size_q, size_d;
    logic           we_q, we_d;
    logic           req_q, req_d;
    logic           mis_q, mis_d;

    logic [BW-1:0]  be_c;
    logic [DW-1:0]  wd_c;
    logic [DW-1:0]  load_c;
    logic [7:0]     byte_c;
    logic [15:0]    half_c;
    logic           misalign_c;

    // Byte enables and lane-replicated store data from the incoming instruction
    always_comb begin
        be_c = 4'b1111;
        wd_c = core_wd_i;
        case (core_size_i[1:0])
            2'b00: begin
                be_c = 4'b0001 << core_addr_i[1:0];
                wd_c = {4{core_wd_i[7:0]}};
            end
            2'b01: begin
                be_c = 4'b0011 << {core_addr_i[1], 1'b0};
                wd_c = {2{core_wd_i[15:0]}};
            end
            default: begin
                be_c = 4'b1111;
                wd_c = core_wd_i;
            end
        endcase
    end

`ifdef LSU_MISALIGN_CHECK_EN
    always_comb begin
        misalign_c = 1'b0;
        if (core_size_i[1:0] == 2'b01)
            misalign_c = core_addr_i[0];
        else if (core_size_i[1:0] != 2'b00)
            misalign_c = (core_addr_i[1:0] != 2'b00);
    end
`else
    assign misalign_c = 1'b0;
`endif

    // Lane extraction uses the registered address/size so it is stable through BUSY
    always_comb begin
        byte_c = mem_rd_i[7:0];
        case (addr_q[1:0])
            2'd0:    byte_c = mem_rd_i[7:0];
            2'd1:    byte_c = mem_rd_i[15:8];
            2'd2:    byte_c = mem_rd_i[23:16];
            default: byte_c = mem_rd_i[31:24];
        endcase
        half_c = addr_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
        case (size_q[1:0])
            2'b00:   load_c = {{24{byte_c[7] & ~size_q[2]}}, byte_c};
            2'b01:   load_c = {{16{half_c[15] & ~size_q[2]}}, half_c};
            default: load_c = mem_rd_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        be_d    = be_q;
        size_d  = size_q;
        we_d    = we_q;
        req_d   = req_q;
        mis_d   = mis_q;
        case (state_q)
            S_IDLE: begin
                if (core_req_i) begin
                    addr_d = core_addr_i;
                    wd_d   = wd_c;
                    be_d   = be_c;
                    size_d = core_size_i;
                    we_d   = core_we_i;
                    if (misalign_c) begin
                        state_d = S_DONE;
                        rd_d    = '0;
                        mis_d   = 1'b1;
                        req_d   = 1'b0;
                    end else begin
                        state_d = S_BUSY;
                        req_d   = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                if (mem_ready_i) begin
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    if (!we_q)
                        rd_d = load_c;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                mis_d   = 1'b0;
                req_d   = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
                mis_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            rd_q    <= '0;
            addr_q  <= '0;
            wd_q    <= '0;
            be_q    <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            req_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            be_q    <= be_d;
            size_q  <= size_d;
            we_q    <= we_d;
            req_q   <= req_d;
            mis_q   <= mis_d;
        end
    end

    assign core_stall_o    = core_req_i && (state_q != S_DONE);
    assign core_rd_o       = rd_q;
    assign core_misalign_o = mis_q;
    assign mem_req_o       = req_q;
    assign mem_we_o        = we_q;
    assign mem_be_o        = be_q;
    assign mem_addr_o      = addr_q;
    assign mem_wd_o        = wd_q;

endmodule

// File: doc/lsu.md
# lsu

Load/store unit of the execute stage, directly downstream of the ALU. It takes the ALU result as the effective address and runs one memory transaction per load/store instruction over a request/ready handshake. It generates byte enables and lane-replicated store data, then returns sign- or zero-extended load data to writeback. It stalls the core for the duration of each access.

## Interface
Parameters:
- none; all widths are fixed (32-bit address and data, 4 byte lanes).

Ports:
- `clk_i` in 1: single clock; all state updates on its rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `core_req_i` in 1: load/store instruction present; held high with operands stable while `core_stall_o`=1.
- `core_we_i` in 1: 1 = store, 0 = load.
- `core_size_i` in 3: funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `core_addr_i` in 32: effective address (ALU `result_o`).
- `core_wd_i` in 32: store data (rs2).
- `core_rd_o` out 32: extended load data; valid in DONE.
- `core_stall_o` out 1: core must hold the current instruction.
- `core_misalign_o` out 1: misaligned access; high only in DONE, only with the check compiled in.
- `mem_req_o` out 1: memory request.
- `mem_we_o` out 1: memory write.
- `mem_be_o` out 4: byte enables.
- `mem_addr_o` out 32: memory address, registered copy of `core_addr_i`.
- `mem_wd_o` out 32: memory write data.
- `mem_rd_i` in 32: memory read data; valid when `mem_ready_i`=1.
- `mem_ready_i` in 1: transaction complete.

## Operation
- FSM states: IDLE, BUSY, DONE.
  - IDLE -> BUSY when `core_req_i`=1 and the access is issuable. Address, we, size, be and wd are registered on this edge.
  - BUSY -> DONE on `mem_ready_i`=1. For loads, `core_rd_o` is registered from `mem_rd_i` on this edge.
  - DONE -> IDLE unconditionally.
- `core_stall_o` = `core_req_i` && state != DONE (combinational).
- `mem_req_o` = 1 exactly while in BUSY. `mem_we_o`, `mem_be_o`, `mem_addr_o` and `mem_wd_o` are constant throughout BUSY.
- Byte enables and store data, with o = `core_addr_i[1:0]`:
  - B: be = 0001 << o; wd = {4{wd[7:0]}}.
  - H: be = 0011 << {o[1],0}; wd = {2{wd[15:0]}}.
  - W: be = 1111; wd = wd.
- Load extraction:
  - B/BU: byte lane o of `mem_rd_i`, sign- or zero-extended to 32 bits.
  - H/HU: halfword lane o[1], sign- or zero-extended to 32 bits.
  - W: whole word.
- Unused size codes 011, 110, 111 are treated as W.
- Stores leave `core_rd_o` unchanged.

## Timing
- Reset values (asynchronous, effective immediately on `rst_ni`=0): state IDLE, `core_rd_o`=0, `mem_req_o`=0, `mem_we_o`=0, `mem_be_o`=0, `mem_addr_o`=0, `mem_wd_o`=0, `core_misalign_o`=0.
- Latency: accept cycle + N BUSY cycles + 1 DONE cycle. With zero-wait memory (`mem_ready_i` high in the first BUSY cycle) a transaction takes 3 cycles and the stall lasts 2 cycles.
- `mem_ready_i` outside BUSY is ignored.
- Reset asserted during BUSY aborts the access: `mem_req_o` falls immediately, no data is captured, and the FSM restarts in IDLE.
- A new `core_req_i` is sampled no earlier than the IDLE cycle after DONE. Back-to-back accesses therefore have one IDLE cycle between them.

## Configuration
- Macro: `LSU_MISALIGN_CHECK_EN`.
- Defined: H/HU with addr[0]=1, or W with addr[1:0]≠00, is misaligned.
  - Misaligned access: IDLE -> DONE directly; `mem_req_o` never asserts.
  - In that DONE cycle `core_misalign_o`=1 and `core_rd_o`=0.
- Undefined:
  - `core_misalign_o` is tied 0.
  - Misaligned low address bits are ignored for lane selection: H uses o[1] only, W uses all lanes.
  - `mem_addr_o` still carries the full address.

## Test plan
- LW, addr 0x100, `mem_rd_i`=0xDEADBEEF, zero-wait memory -> `mem_req_o` high 1 cycle, `mem_be_o`=1111, `core_rd_o`=0xDEADBEEF in DONE, stall high exactly 2 cycles.
- LB / LBU, addr 0x103, `mem_rd_i`=0x80FF_0000 -> `core_rd_o`=0xFFFFFF80 for LB and 0x00000080 for LBU.
- SH, addr 0x102, `core_wd_i`=0x1234ABCD, `mem_ready_i` delayed 4 cycles -> `mem_be_o`=1100 and `mem_wd_o`=0xABCDABCD stable through all 4 BUSY cycles, then DONE.
- SB, addr 0x201, wd=0x55 -> `mem_be_o`=0010, `mem_wd_o`=0x55555555, `mem_we_o`=1.
- `rst_ni` pulsed low in the 2nd BUSY cycle of an LW -> `mem_req_o`=0 immediately, FSM in IDLE, `core_rd_o`=0.
- LW at 0x102:
  - With `LSU_MISALIGN_CHECK_EN`: no `mem_req_o`, `core_misalign_o`=1 for 1 cycle.
  - Without it: normal access with `mem_be_o`=1111.
